// File: rtl/datamemory_arbiter.sv
// datamemory_arbiter: round-robin two-requester sequencer for the single-port word data memory
module datamemory_arbiter #(
  parameter int unsigned DEPTH_BYTES = 128
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_a,
  input  logic        we_a,
  input  logic [31:0] addr_a,
  input  logic [31:0] wdata_a,
  output logic        ack_a,
  output logic        err_a,
  output logic [31:0] rdata_a,
  input  logic        req_b,
  input  logic        we_b,
  input  logic [31:0] addr_b,
  input  logic [31:0] wdata_b,
  output logic        ack_b,
  output logic        err_b,
  output logic [31:0] rdata_b,
  output logic        busy,
  output logic        MemRead,
  output logic        MemWrite,
  output logic [31:0] ReadAddress,
  output logic [31:0] WriteAddress,
  output logic [31:0] WriteData,
  input  logic [31:0] ReadData
);
  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
  state_t state;
  logic lastGrant, grantB, we;
  logic pickB, reqWe, bad;
  logic [31:0] reqAddr, reqWdata;
  always_comb begin
    pickB = req_b && (!req_a || !lastGrant);
    reqWe = pickB ? we_b : we_a;
    reqAddr = pickB ? addr_b : addr_a;
    reqWdata = pickB ? wdata_b : wdata_a;
    bad = (reqAddr[1:0] != 2'b00) || (reqAddr >= 32'(DEPTH_BYTES));
  end
  assign busy = state != IDLE;
  // memory data arrives on the edge entering RESP, so read data passes straight through
  assign rdata_a = (ack_a && !err_a && !we) ? ReadData : '0;
  assign rdata_b = (ack_b && !err_b && !we) ? ReadData : '0;
  // the strobe/address registers double as the latched request, so later input changes are ignored
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      lastGrant <= 1'b1;
      grantB <= 1'b0;
      we <= 1'b0;
      ack_a <= 1'b0;
      ack_b <= 1'b0;
      err_a <= 1'b0;
      err_b <= 1'b0;
      MemRead <= 1'b0;
      MemWrite <= 1'b0;
      ReadAddress <= '0;
      WriteAddress <= '0;
      WriteData <= '0;
    end else begin
      ack_a <= 1'b0;
      ack_b <= 1'b0;
      err_a <= 1'b0;
      err_b <= 1'b0;
      MemRead <= 1'b0;
      MemWrite <= 1'b0;
      ReadAddress <= '0;
      WriteAddress <= '0;
      WriteData <= '0;
      case (state)
        IDLE: if (req_a || req_b) begin
          grantB <= pickB;
          lastGrant <= pickB;
          we <= reqWe;
          if (bad) begin
            state <= RESP;
            ack_a <= !pickB;
            ack_b <= pickB;
            err_a <= !pickB;
            err_b <= pickB;
          end else begin
            state <= ISSUE;
            MemRead <= !reqWe;
            MemWrite <= reqWe;
            ReadAddress <= reqWe ? '0 : reqAddr;
            WriteAddress <= reqWe ? reqAddr : '0;
            WriteData <= reqWe ? reqWdata : '0;
          end
        end
        ISSUE: begin
          state <= RESP;
          ack_a <= !grantB;
          ack_b <= grantB;
        end
        default: state <= IDLE;
      endcase
    end
endmodule
